wb_stage_buf: RTL and testbench

//  Parametrised MEM->WB pipeline boundary replacing the plain per-cycle register stage.

---
 rtl/wb_stage_buf_pkg.sv | 23 ++
 rtl/wb_skid_buf.sv | 94 +++++++++
 rtl/wb_stage_buf.sv | 95 +++++++++
 tb/tb_wb_stage_buf.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_buf_pkg.sv
// Shared constants and types for the MEM->WB stage buffer.
//   NOP_REG_ADDR / ZERO_WORD : reset values for address and data fields
//   WRITEABLE / UNWRITEABLE  : write-enable encodings
//   occ_e                    : occupancy of the 2-entry skid buffer
//   pkt_width()              : packed payload width for a given configuration
package wb_stage_buf_pkg;

    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        WRITEABLE    = 1'b1;
    localparam logic        UNWRITEABLE  = 1'b0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic int pkt_width(input int reg_addr_w, input int data_w, input int hilo_en);
        return reg_addr_w + data_w + 2 + ((hilo_en != 0) ? 2 * data_w : 0);
    endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// Generic 2-entry skid buffer with registered in_ready and synchronous flush.
//   clk, rst             : clock, async active-high reset
//   flush                : empties the buffer on the next edge
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data = head entry
//   skid_valid/skid_data : second (younger) entry, exposed for forwarding
//
// state     | meaning
// OCC_EMPTY | no entry held
// OCC_ONE   | head valid, skid empty
// OCC_TWO   | head and skid valid, upstream stalled
module wb_skid_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         skid_valid,
    output logic [W-1:0] skid_data
);

    occ_e         state, state_nxt;
    logic [W-1:0] head_q, head_nxt;
    logic [W-1:0] skid_q, skid_nxt;
    logic         ready_q, ready_nxt;
    logic         push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            head_q  <= head_nxt;
            skid_q  <= skid_nxt;
            ready_q <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        skid_nxt  = skid_q;
        push      = in_valid && ready_q;
        pop       = (state != OCC_EMPTY) && out_ready;
        case (state)
            OCC_EMPTY: begin
                if (push) begin
                    state_nxt = OCC_ONE;
                    head_nxt  = in_data;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    state_nxt = OCC_TWO;
                    skid_nxt  = in_data;
                end else if (push && pop) begin
                    head_nxt  = in_data;
                end else if (pop) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // ready_q is low here, so no push can coincide with the pop
                if (pop) begin
                    state_nxt = OCC_ONE;
                    head_nxt  = skid_q;
                end
            end
            default: state_nxt = OCC_EMPTY;
        endcase
        // Flush only clears occupancy; payload may go stale since every
        // consumer qualifies it with a valid.
        if (flush) state_nxt = OCC_EMPTY;
        ready_nxt = (state_nxt != OCC_TWO);
    end

    assign in_ready   = ready_q;
    assign out_valid  = (state != OCC_EMPTY);
    assign out_data   = head_q;
    assign skid_valid = (state == OCC_TWO);
    assign skid_data  = skid_q;

endmodule

// File: rtl/wb_stage_buf.sv
// MEM->WB pipeline boundary: valid/ready handshake over a 2-entry skid buffer
// carrying one GPR write-back and an optional HI/LO write-back per slot.
//   clk, rst, flush              : clock, async active-high reset, sync flush
//   in_valid/in_ready, in_*      : MEM-side slot
//   out_valid/out_ready, out_*   : WB-side head entry, enables gated by out_valid
//   fwd1_*                       : skid entry tap for hazard/forwarding logic
//   stall_cnt                    : saturating count of in_valid && !in_ready cycles
module wb_stage_buf
    import wb_stage_buf_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int DATA_W      = 32,
    parameter int HILO_EN     = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ADDR_W-1:0]  in_wd,
    input  logic                   in_wreg,
    input  logic [DATA_W-1:0]      in_wdata,
    input  logic [DATA_W-1:0]      in_hi,
    input  logic [DATA_W-1:0]      in_lo,
    input  logic                   in_enhilo,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_ADDR_W-1:0]  out_wd,
    output logic                   out_wreg,
    output logic [DATA_W-1:0]      out_wdata,
    output logic [DATA_W-1:0]      out_hi,
    output logic [DATA_W-1:0]      out_lo,
    output logic                   out_enhilo,
    output logic [REG_ADDR_W-1:0]  fwd1_wd,
    output logic                   fwd1_wreg,
    output logic [DATA_W-1:0]      fwd1_wdata,
    output logic                   fwd1_enhilo,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int BASE_W = REG_ADDR_W + DATA_W + 2;
    localparam int PKT_W  = pkt_width(REG_ADDR_W, DATA_W, HILO_EN);

    logic [PKT_W-1:0] in_pkt, head_pkt, skid_pkt;
    logic             skid_valid;

    // Base fields sit in the low bits: {enhilo, wreg, wd, wdata}; HI/LO above.
    generate
        if (HILO_EN != 0) begin : g_hilo
            assign in_pkt     = {in_hi, in_lo, in_enhilo, in_wreg, in_wd, in_wdata};
            assign out_hi     = head_pkt[BASE_W+DATA_W +: DATA_W];
            assign out_lo     = head_pkt[BASE_W +: DATA_W];
            assign out_enhilo = head_pkt[BASE_W-1] & out_valid;
            assign fwd1_enhilo = skid_pkt[BASE_W-1] & skid_valid;
        end else begin : g_no_hilo
            assign in_pkt      = {in_enhilo, in_wreg, in_wd, in_wdata};
            assign out_hi      = ZERO_WORD[0 +: DATA_W] & '0;
            assign out_lo      = '0;
            assign out_enhilo  = UNWRITEABLE;
            assign fwd1_enhilo = UNWRITEABLE;
        end
    endgenerate

    wb_skid_buf #(.W(PKT_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_pkt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (head_pkt),
        .skid_valid (skid_valid),
        .skid_data  (skid_pkt)
    );

    assign out_wdata  = head_pkt[0 +: DATA_W];
    assign out_wd     = head_pkt[DATA_W +: REG_ADDR_W];
    assign out_wreg   = head_pkt[DATA_W+REG_ADDR_W] & out_valid;

    assign fwd1_wdata = skid_pkt[0 +: DATA_W];
    assign fwd1_wd    = skid_pkt[DATA_W +: REG_ADDR_W];
    assign fwd1_wreg  = skid_pkt[DATA_W+REG_ADDR_W] & skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage_buf.sv
module tb_wb_stage_buf;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        enhilo;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [4:0]  in_wd;
    logic        in_wreg, in_enhilo;
    logic [31:0] in_wdata, in_hi, in_lo;

    logic        in_ready, out_valid, out_wreg, out_enhilo, fwd1_wreg, fwd1_enhilo;
    logic [4:0]  out_wd, fwd1_wd;
    logic [31:0] out_wdata, out_hi, out_lo, fwd1_wdata;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, out_wreg2, out_enhilo2, fwd1_wreg2, fwd1_enhilo2;
    logic [4:0]  out_wd2, fwd1_wd2;
    logic [31:0] out_wdata2, out_hi2, out_lo2, fwd1_wdata2;
    logic [3:0]  stall_cnt2;

    int errors = 0;
    int checks = 0;

    pkt_t q[$];
    int   exp_cnt16 = 0;
    int   exp_cnt4  = 0;

    always #5 clk = ~clk;

    wb_stage_buf dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_enhilo(in_enhilo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
        .out_hi(out_hi), .out_lo(out_lo), .out_enhilo(out_enhilo),
        .fwd1_wd(fwd1_wd), .fwd1_wreg(fwd1_wreg), .fwd1_wdata(fwd1_wdata),
        .fwd1_enhilo(fwd1_enhilo), .stall_cnt(stall_cnt)
    );

    wb_stage_buf #(.HILO_EN(0), .STALL_CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .in_hi(in_hi), .in_lo(in_lo), .in_enhilo(in_enhilo),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_wd(out_wd2), .out_wreg(out_wreg2), .out_wdata(out_wdata2),
        .out_hi(out_hi2), .out_lo(out_lo2), .out_enhilo(out_enhilo2),
        .fwd1_wd(fwd1_wd2), .fwd1_wreg(fwd1_wreg2), .fwd1_wdata(fwd1_wdata2),
        .fwd1_enhilo(fwd1_enhilo2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("in_ready", 64'(in_ready), 64'(n < 2));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        chk("in_ready2", 64'(in_ready2), 64'(n < 2));
        chk("out_valid2", 64'(out_valid2), 64'(n > 0));
        if (n > 0) begin
            chk("out_wd", 64'(out_wd), 64'(q[0].wd));
            chk("out_wdata", 64'(out_wdata), 64'(q[0].wdata));
            chk("out_wreg", 64'(out_wreg), 64'(q[0].wreg));
            chk("out_hi", 64'(out_hi), 64'(q[0].hi));
            chk("out_lo", 64'(out_lo), 64'(q[0].lo));
            chk("out_enhilo", 64'(out_enhilo), 64'(q[0].enhilo));
            chk("out_wd2", 64'(out_wd2), 64'(q[0].wd));
            chk("out_wdata2", 64'(out_wdata2), 64'(q[0].wdata));
            chk("out_wreg2", 64'(out_wreg2), 64'(q[0].wreg));
        end else begin
            chk("out_wreg_idle", 64'(out_wreg), 64'd0);
            chk("out_enhilo_idle", 64'(out_enhilo), 64'd0);
            chk("out_wreg2_idle", 64'(out_wreg2), 64'd0);
        end
        if (n == 2) begin
            chk("fwd1_wd", 64'(fwd1_wd), 64'(q[1].wd));
            chk("fwd1_wdata", 64'(fwd1_wdata), 64'(q[1].wdata));
            chk("fwd1_wreg", 64'(fwd1_wreg), 64'(q[1].wreg));
            chk("fwd1_enhilo", 64'(fwd1_enhilo), 64'(q[1].enhilo));
            chk("fwd1_wd2", 64'(fwd1_wd2), 64'(q[1].wd));
            chk("fwd1_wreg2", 64'(fwd1_wreg2), 64'(q[1].wreg));
        end else begin
            chk("fwd1_wreg_idle", 64'(fwd1_wreg), 64'd0);
            chk("fwd1_enhilo_idle", 64'(fwd1_enhilo), 64'd0);
            chk("fwd1_wreg2_idle", 64'(fwd1_wreg2), 64'd0);
        end
        chk("hilo0_out_enhilo", 64'(out_enhilo2), 64'd0);
        chk("hilo0_fwd1_enhilo", 64'(fwd1_enhilo2), 64'd0);
        chk("hilo0_out_hi", 64'(out_hi2), 64'd0);
        chk("hilo0_out_lo", 64'(out_lo2), 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_cnt16));
        chk("stall_cnt4", 64'(stall_cnt2), 64'(exp_cnt4));
    endtask

    // One clock: update the reference FIFO from the inputs seen at the edge.
    task automatic tick();
        bit   can_take;
        bit   take, give;
        pkt_t p;
        can_take = (q.size() < 2);
        p.wd = in_wd; p.wreg = in_wreg; p.wdata = in_wdata;
        p.hi = in_hi; p.lo = in_lo; p.enhilo = in_enhilo;
        @(posedge clk);
        if (in_valid && !can_take) begin
            if (exp_cnt16 < 65535) exp_cnt16++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        if (flush) begin
            q.delete();
        end else begin
            take = in_valid && can_take;
            give = (q.size() > 0) && out_ready;
            if (give) void'(q.pop_front());
            if (take) q.push_back(p);
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [4:0] wd, input bit rnd);
        in_valid  = v;
        in_wd     = wd;
        in_wreg   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_wdata  = rnd ? $urandom : {27'h0, wd} + 32'h100;
        in_hi     = rnd ? $urandom : 32'hDEAD;
        in_lo     = rnd ? $urandom : 32'hBEEF;
        in_enhilo = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        q.delete();
        exp_cnt16 = 0;
        exp_cnt4  = 0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        #1;
        chk("rst_out_wd", 64'(out_wd), 64'd0);
        chk("rst_out_wdata", 64'(out_wdata), 64'd0);
        chk("rst_fwd1_wd", 64'(fwd1_wd), 64'd0);
        chk("rst_fwd1_wdata", 64'(fwd1_wdata), 64'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // streaming, back-to-back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 1'b0);
            tick();
            chk("stream_wd", 64'(out_wd), 64'(i));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 5'd0, 1'b0);
        tick();

        // backpressure
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b0); tick();
        drive(1'b1, 5'd4, 1'b0); tick();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_fwd1_wd", 64'(fwd1_wd), 64'd4);
        chk("bp_fwd1_wreg", 64'(fwd1_wreg), 64'd1);
        drive(1'b1, 5'd9, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
        drive(1'b0, 5'd0, 1'b0);
        out_ready = 1'b1;
        chk("bp_head", 64'(out_wd), 64'd3);
        tick();
        chk("bp_second", 64'(out_wd), 64'd4);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        tick();

        // flush while full, with push and pop attempted
        out_ready = 1'b0;
        drive(1'b1, 5'd11, 1'b0); tick();
        drive(1'b1, 5'd12, 1'b0); tick();
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 5'd13, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_fwd1_wreg", 64'(fwd1_wreg), 64'd0);
        chk("flush_out_wreg", 64'(out_wreg), 64'd0);
        drive(1'b0, 5'd0, 1'b0);
        tick();

        // reset mid-stream while full
        out_ready = 1'b0;
        drive(1'b1, 5'd20, 1'b0); tick();
        drive(1'b1, 5'd21, 1'b0); tick();
        tick();
        do_reset();
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_stall", 64'(stall_cnt), 64'd0);

        // saturation of the 4-bit counter
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b0);
        for (int i = 0; i < 22; i++) tick();
        chk("sat_cnt4", 64'(stall_cnt2), 64'hF);
        chk("sat_cnt16", 64'(stall_cnt), 64'd20);
        tick();
        chk("sat_hold", 64'(stall_cnt2), 64'hF);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'b1);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
